// File: rtl/in_responder_pkg.sv
// Shared types for the IN-instruction responder: FSM encoding, default word width
// and the debounce counter width helper.
package in_responder_pkg;

  localparam int DATA_W_DEF = 18;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_WAIT_PRESS = 3'd2,
    ST_ACK        = 3'd3,
    ST_RELEASE    = 3'd4
  } state_t;

  // Keep at least one bit so a single-cycle debounce still elaborates.
  function automatic int cnt_w(input int cyc);
    return (cyc > 1) ? $clog2(cyc) : 1;
  endfunction

endpackage

// File: rtl/in_responder_button_debounce.sv
// Enter-key conditioning: 2-FF synchroniser, polarity fix, stability counter,
// accepted level and a one-cycle pulse on each accepted press.
module button_debounce
  import in_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 250000,
  parameter bit KEY_ACT_LOW  = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic pressed,
  output logic press_evt
);

  localparam int            CW       = cnt_w(DEBOUNCE_CYC);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYC - 1);
  localparam logic          IDLE_LVL = KEY_ACT_LOW;

  logic [1:0]    sync_q;
  logic          raw_pressed;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) sync_q <= {2{IDLE_LVL}};
    else       sync_q <= {sync_q[0], key};
  end

  assign raw_pressed = sync_q[1] ^ IDLE_LVL;

  // Counter only runs while the raw level disagrees with the accepted one;
  // it is cleared on acceptance, so it never passes CNT_MAX.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      pressed   <= 1'b0;
      press_evt <= 1'b0;
    end else begin
      press_evt <= 1'b0;
      if (raw_pressed == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        cnt       <= '0;
        pressed   <= raw_pressed;
        press_evt <= raw_pressed;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/in_responder.sv
// Responder for the IN instruction: four-phase req/ack with the control unit,
// capturing the synchronised switch word on a fresh debounced enter press.
module in_responder
  import in_responder_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DEBOUNCE_CYC = 250000,
  parameter bit KEY_ACT_LOW  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic [DATA_W-1:0] entrada,
  input  logic              in_req,
  output logic              sinal,
  output logic [DATA_W-1:0] valor,
  output logic              waiting
);

  state_t                 state, state_nx;
  logic                   key_pressed, press_evt, capture;
  logic [1:0][DATA_W-1:0] ent_sync;

  button_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .KEY_ACT_LOW  (KEY_ACT_LOW)
  ) u_dbnc (
    .clock     (clock),
    .reset     (reset),
    .key       (enter),
    .pressed   (key_pressed),
    .press_evt (press_evt)
  );

  always_ff @(posedge clock) begin
    if (reset) ent_sync <= '0;
    else       ent_sync <= {ent_sync[0], entrada};
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // A key already held when a request opens must be released first (ARM),
  // and a request dropping in the same cycle as a press aborts without capture.
  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      ST_IDLE:
        if (in_req) state_nx = key_pressed ? ST_ARM : ST_WAIT_PRESS;
      ST_ARM:
        if (!in_req)          state_nx = ST_IDLE;
        else if (!key_pressed) state_nx = ST_WAIT_PRESS;
      ST_WAIT_PRESS:
        if (!in_req) begin
          state_nx = ST_IDLE;
        end else if (press_evt) begin
          state_nx = ST_ACK;
          capture  = 1'b1;
        end
      ST_ACK:
        if (!in_req) state_nx = ST_RELEASE;
      ST_RELEASE:
        if (in_req)            state_nx = key_pressed ? ST_ARM : ST_WAIT_PRESS;
        else if (!key_pressed) state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    sinal   = (state == ST_ACK);
    waiting = (state == ST_WAIT_PRESS);
  end

  always_ff @(posedge clock) begin
    if (reset)        valor <= '0;
    else if (capture) valor <= ent_sync[1];
  end

endmodule
